// File: rtl/faerie_mem_arbiter.sv
// Shares the single memory port between the CPU and a DMA/debug requester.
// The CPU is stalled through cpu_ce whenever the DMA takes a cycle it also wanted.
module faerie_mem_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int LOCK_MAX     = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_re,
   input  logic        cpu_we,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   output logic        cpu_ce,
   output logic [7:0]  cpu_rdata,
   input  logic        dma_req,
   input  logic        dma_we,
   input  logic        dma_lock,
   input  logic [15:0] dma_addr,
   input  logic [7:0]  dma_wdata,
   output logic        dma_gnt,
   output logic [7:0]  dma_rdata,
   output logic        dma_rvalid,
   output logic        mem_re,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata
);

   // state    | meaning
   // OWN_CPU  | read issued last cycle belongs to the CPU
   // OWN_DMA  | read issued last cycle belongs to the DMA
   typedef enum logic {OWN_CPU, OWN_DMA} owner_e;

   owner_e      rd_owner_q, rd_owner_d;
   logic        rd_pend_q,  rd_pend_d;
   logic        locked_q,   locked_d;
   logic [3:0]  starve_q,   starve_d;
   logic [3:0]  lock_cnt_q, lock_cnt_d;
   logic [7:0]  hold_q,     hold_d;

   logic        cpu_idle;
   logic        dma_own;
   logic        cpu_ret;

   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_owner_q <= OWN_CPU;
         rd_pend_q  <= 1'b0;
         locked_q   <= 1'b0;
         starve_q   <= 4'd0;
         lock_cnt_q <= 4'd0;
         hold_q     <= 8'd0;
      end else begin
         rd_owner_q <= rd_owner_d;
         rd_pend_q  <= rd_pend_d;
         locked_q   <= locked_d;
         starve_q   <= starve_d;
         lock_cnt_q <= lock_cnt_d;
         hold_q     <= hold_d;
      end
   end

   always_comb begin
      cpu_idle = !cpu_re && !cpu_we;
      dma_own  = dma_req && (cpu_idle
                             || (starve_q == 4'(STARVE_LIMIT))
                             || (locked_q && (lock_cnt_q < 4'(LOCK_MAX))));

      // Outputs are forced while reset is held so the CPU's own reset proceeds.
      dma_gnt   = rst && dma_own;
      cpu_ce    = !rst || !dma_own || cpu_idle;
      mem_re    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = 16'd0;
      mem_wdata = 8'd0;
      if (rst) begin
         if (dma_own) begin
            mem_re    = !dma_we;
            mem_we    = dma_we;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
         end else begin
            mem_re    = cpu_re && !cpu_we;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
         end
      end

      dma_rvalid = rst && rd_pend_q && (rd_owner_q == OWN_DMA);
      dma_rdata  = dma_rvalid ? mem_rdata : 8'd0;
      cpu_ret    = rst && rd_pend_q && (rd_owner_q == OWN_CPU);
      // Bypass on the return cycle keeps the CPU's 1-cycle read latency even if it stalls next.
      cpu_rdata  = !rst ? 8'd0 : (cpu_ret ? mem_rdata : hold_q);
      hold_d     = cpu_ret ? mem_rdata : hold_q;

      rd_pend_d  = mem_re;
      rd_owner_d = dma_gnt ? OWN_DMA : OWN_CPU;

      if (!dma_req || dma_gnt)
         starve_d = 4'd0;
      else if (starve_q == 4'(STARVE_LIMIT))
         starve_d = starve_q;
      else
         starve_d = starve_q + 4'd1;

      locked_d = dma_gnt && dma_lock;
      if (!dma_gnt)
         lock_cnt_d = 4'd0;
      else if (lock_cnt_q == 4'(LOCK_MAX))
         lock_cnt_d = lock_cnt_q;
      else
         lock_cnt_d = lock_cnt_q + 4'd1;
   end

endmodule

// File: tb/tb_faerie_mem_arbiter.sv
// Directed bench for faerie_mem_arbiter: reset, DMA read, starvation, stall hold,
// lock bursts and reset during a pending read.
module tb_faerie_mem_arbiter;

   logic        clk;
   logic        rst;
   logic        cpu_re, cpu_we;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_ce;
   logic [7:0]  cpu_rdata;
   logic        dma_req, dma_we, dma_lock;
   logic [15:0] dma_addr;
   logic [7:0]  dma_wdata;
   logic        dma_gnt;
   logic [7:0]  dma_rdata;
   logic        dma_rvalid;
   logic        mem_re, mem_we;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;

   int n_pass  = 0;
   int n_total = 0;

   faerie_mem_arbiter #(.STARVE_LIMIT(4), .LOCK_MAX(8)) dut (
      .clk(clk), .rst(rst),
      .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ce(cpu_ce), .cpu_rdata(cpu_rdata),
      .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock),
      .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
      .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Inputs change just after the active edge; checks happen on the falling edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      cpu_re = 0; cpu_we = 0; cpu_addr = 16'h0; cpu_wdata = 8'h0;
      dma_req = 0; dma_we = 0; dma_lock = 0; dma_addr = 16'h0; dma_wdata = 8'h0;
      mem_rdata = 8'h0;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         step();
         rst = 0;
         cpu_re = 1; cpu_we = 1; cpu_addr = 16'hFFFF; cpu_wdata = 8'hFF;
         dma_req = 1; dma_we = 0; dma_lock = 1; dma_addr = 16'hAAAA; dma_wdata = 8'h55;
         mem_rdata = 8'hFF;
         @(negedge clk);
         n_total++;
         if (cpu_ce !== 1'b1 || dma_gnt !== 1'b0 || mem_re !== 1'b0 || mem_we !== 1'b0)
            $display("FAIL reset_ctl cyc%0d: ce=%b gnt=%b re=%b we=%b, want 1 0 0 0",
                     i, cpu_ce, dma_gnt, mem_re, mem_we);
         else n_pass++;
         n_total++;
         if (cpu_rdata !== 8'h00 || mem_addr !== 16'h0 || mem_wdata !== 8'h00 || dma_rvalid !== 1'b0)
            $display("FAIL reset_data cyc%0d: rdata=%h addr=%h wdata=%h rvalid=%b, want 00 0000 00 0",
                     i, cpu_rdata, mem_addr, mem_wdata, dma_rvalid);
         else n_pass++;
      end
      step();
      rst = 1;
      drive_idle();
   endtask

   task automatic test_dma_read();
      step();
      dma_req = 1; dma_we = 0; dma_addr = 16'h1234;
      @(negedge clk);
      n_total++;
      if (dma_gnt !== 1'b1 || mem_re !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h1234 || cpu_ce !== 1'b1)
         $display("FAIL dma_read_issue: gnt=%b re=%b we=%b addr=%h ce=%b, want 1 1 0 1234 1",
                  dma_gnt, mem_re, mem_we, mem_addr, cpu_ce);
      else n_pass++;
      step();
      drive_idle();
      mem_rdata = 8'hA5;
      @(negedge clk);
      n_total++;
      if (dma_rvalid !== 1'b1 || dma_rdata !== 8'hA5 || cpu_ce !== 1'b1 || dma_gnt !== 1'b0)
         $display("FAIL dma_read_return: rvalid=%b rdata=%h ce=%b gnt=%b, want 1 a5 1 0",
                  dma_rvalid, dma_rdata, cpu_ce, dma_gnt);
      else n_pass++;
      step();
      mem_rdata = 8'h00;
      @(negedge clk);
      n_total++;
      if (dma_rvalid !== 1'b0)
         $display("FAIL dma_rvalid_drop: rvalid=%b, want 0", dma_rvalid);
      else n_pass++;
   endtask

   task automatic test_starve();
      logic exp_gnt;
      for (int i = 0; i < 10; i++) begin
         step();
         cpu_re = 1; cpu_addr = 16'h0100;
         dma_req = 1; dma_we = 0; dma_addr = 16'h0200;
         exp_gnt = ((i % 5) == 4);
         @(negedge clk);
         n_total++;
         if (dma_gnt !== exp_gnt || cpu_ce !== !exp_gnt || mem_re !== 1'b1)
            $display("FAIL starve cyc%0d: gnt=%b ce=%b re=%b, want %b %b 1",
                     i, dma_gnt, cpu_ce, mem_re, exp_gnt, !exp_gnt);
         else n_pass++;
      end
      step();
      drive_idle();
   endtask

   task automatic test_stall_hold();
      for (int i = 0; i < 4; i++) begin
         step();
         cpu_re = 1; cpu_addr = (i == 3) ? 16'h0042 : 16'h0040;
         dma_req = 1; dma_we = 1; dma_addr = 16'hBEEF; dma_wdata = 8'h11;
         mem_rdata = 8'h00;
         @(negedge clk);
         n_total++;
         if (dma_gnt !== 1'b0 || mem_addr !== cpu_addr)
            $display("FAIL stall_prefix cyc%0d: gnt=%b addr=%h, want 0 %h", i, dma_gnt, mem_addr, cpu_addr);
         else n_pass++;
      end
      step();
      cpu_addr = 16'h0043;
      mem_rdata = 8'h3C;
      @(negedge clk);
      n_total++;
      if (dma_gnt !== 1'b1 || cpu_ce !== 1'b0 || cpu_rdata !== 8'h3C || mem_we !== 1'b1 || mem_addr !== 16'hBEEF)
         $display("FAIL stall_forced: gnt=%b ce=%b rdata=%h we=%b addr=%h, want 1 0 3c 1 beef",
                  dma_gnt, cpu_ce, cpu_rdata, mem_we, mem_addr);
      else n_pass++;
      step();
      dma_req = 0; dma_we = 0;
      mem_rdata = 8'h77;
      @(negedge clk);
      n_total++;
      if (cpu_rdata !== 8'h3C || cpu_ce !== 1'b1 || mem_re !== 1'b1 || mem_addr !== 16'h0043)
         $display("FAIL stall_hold: rdata=%h ce=%b re=%b addr=%h, want 3c 1 1 0043",
                  cpu_rdata, cpu_ce, mem_re, mem_addr);
      else n_pass++;
      step();
      drive_idle();
      mem_rdata = 8'h5A;
      @(negedge clk);
      n_total++;
      if (cpu_rdata !== 8'h5A)
         $display("FAIL stall_next_return: rdata=%h, want 5a", cpu_rdata);
      else n_pass++;
      step();
      mem_rdata = 8'h99;
      @(negedge clk);
      n_total++;
      if (cpu_rdata !== 8'h5A)
         $display("FAIL stall_rehold: rdata=%h, want 5a", cpu_rdata);
      else n_pass++;
      step();
      drive_idle();
   endtask

   task automatic test_lock_burst();
      for (int i = 0; i < 9; i++) begin
         step();
         dma_req = 1; dma_we = 1; dma_lock = 1; dma_addr = 16'h2000 + 16'(i); dma_wdata = 8'hD0;
         cpu_we = (i != 0); cpu_addr = 16'h3000; cpu_wdata = 8'h5E;
         @(negedge clk);
         n_total++;
         if (i < 8) begin
            if (dma_gnt !== 1'b1 || cpu_ce !== (i == 0) || mem_addr !== dma_addr || mem_we !== 1'b1)
               $display("FAIL lock_grant cyc%0d: gnt=%b ce=%b addr=%h we=%b, want 1 %b %h 1",
                        i, dma_gnt, cpu_ce, mem_addr, mem_we, (i == 0), dma_addr);
            else n_pass++;
         end else begin
            if (dma_gnt !== 1'b0 || cpu_ce !== 1'b1 || mem_we !== 1'b1 || mem_re !== 1'b0
                || mem_addr !== 16'h3000 || mem_wdata !== 8'h5E)
               $display("FAIL lock_release: gnt=%b ce=%b we=%b re=%b addr=%h wdata=%h, want 0 1 1 0 3000 5e",
                        dma_gnt, cpu_ce, mem_we, mem_re, mem_addr, mem_wdata);
            else n_pass++;
         end
      end
      step();
      drive_idle();
   endtask

   task automatic test_lock_drop();
      step();
      dma_req = 1; dma_we = 1; dma_lock = 1; dma_addr = 16'h4000;
      @(negedge clk);
      step();
      dma_req = 0; cpu_we = 1; cpu_addr = 16'h4100;
      @(negedge clk);
      step();
      dma_req = 1;
      @(negedge clk);
      n_total++;
      if (dma_gnt !== 1'b0 || mem_addr !== 16'h4100 || cpu_ce !== 1'b1)
         $display("FAIL lock_drop: gnt=%b addr=%h ce=%b, want 0 4100 1", dma_gnt, mem_addr, cpu_ce);
      else n_pass++;
      step();
      drive_idle();
   endtask

   task automatic test_rw_priority();
      step();
      cpu_re = 1; cpu_we = 1; cpu_addr = 16'h5555; cpu_wdata = 8'hC3;
      @(negedge clk);
      n_total++;
      if (mem_we !== 1'b1 || mem_re !== 1'b0 || mem_addr !== 16'h5555 || mem_wdata !== 8'hC3)
         $display("FAIL rw_priority: we=%b re=%b addr=%h wdata=%h, want 1 0 5555 c3",
                  mem_we, mem_re, mem_addr, mem_wdata);
      else n_pass++;
      step();
      drive_idle();
      mem_rdata = 8'hE1;
      @(negedge clk);
      n_total++;
      if (cpu_rdata !== 8'h5A || mem_re !== 1'b0 || mem_we !== 1'b0 || cpu_ce !== 1'b1)
         $display("FAIL idle_no_return: rdata=%h re=%b we=%b ce=%b, want 5a 0 0 1",
                  cpu_rdata, mem_re, mem_we, cpu_ce);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      step();
      drive_idle();
      dma_req = 1; dma_addr = 16'h1111;
      @(negedge clk);
      n_total++;
      if (dma_gnt !== 1'b1 || mem_re !== 1'b1)
         $display("FAIL rstmid_issue: gnt=%b re=%b, want 1 1", dma_gnt, mem_re);
      else n_pass++;
      step();
      rst = 0;
      mem_rdata = 8'hEE;
      @(negedge clk);
      n_total++;
      if (dma_rvalid !== 1'b0 || dma_gnt !== 1'b0 || mem_re !== 1'b0 || mem_addr !== 16'h0
          || cpu_ce !== 1'b1 || cpu_rdata !== 8'h00)
         $display("FAIL rstmid_during: rvalid=%b gnt=%b re=%b addr=%h ce=%b rdata=%h, want 0 0 0 0000 1 00",
                  dma_rvalid, dma_gnt, mem_re, mem_addr, cpu_ce, cpu_rdata);
      else n_pass++;
      step();
      rst = 1;
      drive_idle();
      mem_rdata = 8'hEE;
      @(negedge clk);
      n_total++;
      if (dma_rvalid !== 1'b0 || cpu_rdata !== 8'h00)
         $display("FAIL rstmid_after: rvalid=%b rdata=%h, want 0 00", dma_rvalid, cpu_rdata);
      else n_pass++;
   endtask

   initial begin
      rst = 0;
      drive_idle();
      test_reset();
      test_dma_read();
      test_starve();
      test_stall_hold();
      test_lock_burst();
      test_lock_drop();
      test_rw_priority();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/faerie_mem_arbiter.md
Name: faerie_mem_arbiter

Overview:
- Shares Faerie's single 8-bit, 16-bit-address memory port between the CPU (control unit plus datapath) and a DMA/debug requester.
- Holds the CPU with a clock-enable whenever the DMA owns a cycle.
- Keeps read data for the CPU stable while it is stalled, so the CPU still sees the 1-cycle read latency it is built around.
- Sits between the core and the memory/MMIO fabric.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles the DMA may be refused before it is force-granted (range 1..15).
- LOCK_MAX, 8: maximum consecutive DMA grants under dma_lock (range 1..15).

Ports:
- clk  in  1  CPU clock.
- rst  in  1  Synchronous reset, active-low: asserted while 0, sampled on posedge clk.
- cpu_re  in  1  CPU read request for this cycle.
- cpu_we  in  1  CPU write request for this cycle.
- cpu_addr  in  16  CPU address.
- cpu_wdata  in  8  CPU write data.
- cpu_ce  out  1  CPU clock-enable. When 0, the CPU holds all of its state.
- cpu_rdata  out  8  Read data for the CPU, held between returns.
- dma_req  in  1  DMA access request, level.
- dma_we  in  1  1 = write, 0 = read.
- dma_lock  in  1  Keep the bus after the current grant.
- dma_addr  in  16  DMA address.
- dma_wdata  in  8  DMA write data.
- dma_gnt  out  1  The DMA access is issued this cycle.
- dma_rdata  out  8  DMA read data.
- dma_rvalid  out  1  dma_rdata is valid this cycle.
- mem_re  out  1  Memory read enable.
- mem_we  out  1  Memory write enable.
- mem_addr  out  16  Memory address.
- mem_wdata  out  8  Memory write data.
- mem_rdata  in  8  Memory read data, valid 1 cycle after mem_re.

Behaviour:
- Reset (rst=0):
  - cpu_ce=1, so the CPU's own reset proceeds.
  - dma_gnt=0, mem_re=0, mem_we=0, dma_rvalid=0.
  - mem_addr=0, mem_wdata=0, cpu_rdata=0.
  - Starve and lock counters=0, owner=CPU.
  - Reset mid-access discards any pending read return.
- Grant decision is combinational and made every cycle. Exactly one owner per cycle.
  - DMA owns the cycle if dma_req && (cpu idle (!cpu_re && !cpu_we) || starve_cnt==STARVE_LIMIT || (locked && lock_cnt<LOCK_MAX)).
  - Otherwise the CPU owns it.
- When the DMA owns the cycle:
  - dma_gnt=1, cpu_ce = cpu idle.
  - mem_* are driven from the dma_* inputs: mem_re=!dma_we, mem_we=dma_we.
- When the CPU owns the cycle:
  - cpu_ce=1, dma_gnt=0.
  - mem_* are driven from the cpu_* inputs.
  - If cpu_re and cpu_we are both 1, mem_we wins and mem_re=0.
- When neither side requests: CPU path, mem_re=mem_we=0, cpu_ce=1.
- Starve counter (4-bit):
  - Increments on dma_req && !dma_gnt, saturating at STARVE_LIMIT.
  - Clears on dma_gnt or !dma_req.
- Lock:
  - locked is set after a DMA grant with dma_lock=1.
  - locked clears on any cycle without a DMA grant, or when dma_lock=0.
  - lock_cnt counts consecutive DMA grants and clears when a grant goes to the CPU or nobody.
  - When lock_cnt reaches LOCK_MAX with a CPU request pending, the CPU gets the next cycle even if dma_lock=1.
- Read return:
  - One-bit rd_owner and rd_pend registers capture the read issue.
  - In the cycle after a DMA read: dma_rvalid=1, dma_rdata=mem_rdata.
  - In the cycle after a CPU read: cpu_rdata=mem_rdata, combinational bypass, and the value is also stored in a holding register.
  - In all other cycles, including stalls, cpu_rdata = holding register.
  - A new issue in the return cycle is allowed: back-to-back reads are fully pipelined.
- Simultaneous events:
  - Forced starve grant and a CPU request in the same cycle: DMA wins.
  - dma_req deasserted while locked: the lock ends immediately.

Test Plan:
- Reset hold: rst=0 for 3 cycles with all requests active -> cpu_ce=1, dma_gnt=0, mem_re=mem_we=0, cpu_rdata=0.
- CPU idle, DMA read addr 0x1234, memory returns 0xA5 -> dma_gnt=1 in cycle t with mem_addr=0x1234 and mem_re=1; dma_rvalid=1 and dma_rdata=0xA5 in t+1; cpu_ce=1 throughout.
- CPU reads every cycle and dma_req is held (STARVE_LIMIT=4) -> 4 CPU cycles, then 1 DMA grant with cpu_ce=0; the pattern repeats; the starve counter never exceeds 4.
- CPU reads 0x0042 (memory returns 0x3C) and a DMA grant is forced in the return cycle -> cpu_rdata=0x3C in the return cycle and stays 0x3C through the stall until the next CPU read returns.
- DMA burst with dma_lock=1 and a CPU write pending (LOCK_MAX=8) -> exactly 8 consecutive dma_gnt; cycle 9 has mem_we=1 with the CPU address and data, cpu_ce=1.
- Assert rst=0 in the cycle after a DMA read issue -> no dma_rvalid afterwards, and all outputs take their reset values.
